// File: rtl/countdown_timer.sv
// countdown_timer: MMIO 32-bit down-counting timer with prescaler, reload, one-shot/periodic modes and sticky tc irq
module countdown_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    typedef enum logic {IDLE, RUN} state_e;
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
    state_e      state_q, state_d;
    logic [31:0] load_q, load_d, value_q, value_d;
    logic [15:0] pre_q, pre_d;
    logic        periodic_q, periodic_d, irq_en_q, irq_en_d, tc_q, tc_d;
    logic        ctrl_wr, load_wr, value_wr, status_wr, start, tick, expire;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            load_q     <= '0;
            value_q    <= '0;
            pre_q      <= '0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_q     <= load_d;
            value_q    <= value_d;
            pre_q      <= pre_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            tc_q       <= tc_d;
        end
    end
    always_comb begin
        ctrl_wr    = sel && we && addr == 2'd0;
        load_wr    = sel && we && addr == 2'd1;
        value_wr   = sel && we && addr == 2'd2;
        status_wr  = sel && we && addr == 2'd3;
        start      = ctrl_wr && wdata[0] && state_q == IDLE;
        tick       = state_q == RUN && pre_q == PRE_MAX;
        expire     = tick && value_q == '0;
        pre_d      = start ? '0 : state_q == RUN ? (tick ? '0 : pre_q + 16'd1) : pre_q;
        value_d    = value_wr ? wdata :
                     start ? load_q :
                     !tick ? value_q :
                     value_q != '0 ? value_q - 32'd1 :
                     periodic_q ? load_q : value_q;
        load_d     = load_wr ? wdata : load_q;
        periodic_d = ctrl_wr ? wdata[1] : periodic_q;
        irq_en_d   = ctrl_wr ? wdata[2] : irq_en_q;
        tc_d       = expire || (tc_q && !(status_wr && wdata[0]));
        state_d    = (expire && !periodic_q) ? IDLE :
                     ctrl_wr ? (wdata[0] ? RUN : IDLE) : state_q;
        rdata      = addr == 2'd0 ? {29'd0, irq_en_q, periodic_q, state_q == RUN} :
                     addr == 2'd1 ? load_q :
                     addr == 2'd2 ? value_q : {31'd0, tc_q};
    end
    assign irq = tc_q & irq_en_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: random and directed checks of two timers (PRESCALE 1 and 4) against a behavioural model
module tb_countdown_timer;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0, rdata1, rdata4;
    logic        irq1, irq4;
    int          total = 0, bad = 0;
    bit          chk_en = 1'b0;
    int unsigned m_val[2], m_load[2], m_pre[2];
    bit          m_run[2], m_per[2], m_ie[2], m_tc[2];
    int unsigned ps[2] = '{1, 4};

    always #5 clk = ~clk;

    countdown_timer #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
                                          .wdata(wdata), .rdata(rdata1), .irq(irq1));
    countdown_timer #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
                                          .wdata(wdata), .rdata(rdata4), .irq(irq4));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input int k, input logic [1:0] a);
        case (a)
            2'd0: return {29'd0, m_ie[k], m_per[k], m_run[k]};
            2'd1: return m_load[k];
            2'd2: return m_val[k];
            default: return {31'd0, m_tc[k]};
        endcase
    endfunction

    function automatic void mstep(input bit s, input bit w, input logic [1:0] a, input logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            bit wr = s && w;
            bit tick = m_run[k] && m_pre[k] == ps[k] - 1;
            bit expire = tick && m_val[k] == 0;
            bit enable = wr && a == 2'd0 && d[0] && !m_run[k];
            int unsigned nval = m_val[k];
            if (rst) begin
                m_val[k] = 0; m_load[k] = 0; m_pre[k] = 0;
                m_run[k] = 0; m_per[k] = 0; m_ie[k] = 0; m_tc[k] = 0;
                continue;
            end
            if (enable) nval = m_load[k];
            else if (tick) nval = m_val[k] > 0 ? m_val[k] - 1 : (m_per[k] ? m_load[k] : 0);
            if (wr && a == 2'd2) nval = d;
            if (enable) m_pre[k] = 0;
            else if (m_run[k]) m_pre[k] = tick ? 0 : m_pre[k] + 1;
            if (wr && a == 2'd3 && d[0]) m_tc[k] = 0;
            if (expire) m_tc[k] = 1;
            if (expire && !m_per[k]) m_run[k] = 0;
            else if (wr && a == 2'd0) m_run[k] = d[0];
            if (wr && a == 2'd0) begin
                m_per[k] = d[1];
                m_ie[k] = d[2];
            end
            if (wr && a == 2'd1) m_load[k] = d;
            m_val[k] = nval;
        end
    endfunction

    task automatic step(input bit s, input bit w, input logic [1:0] a, input logic [31:0] d);
        sel = s; we = w; addr = a; wdata = d;
        #1;
        if (chk_en) begin
            chk("model_rd1", rdata1, mread(0, a));
            chk("model_irq1", {31'd0, irq1}, {31'd0, m_tc[0] & m_ie[0]});
            chk("model_rd4", rdata4, mread(1, a));
            chk("model_irq4", {31'd0, irq4}, {31'd0, m_tc[1] & m_ie[1]});
        end
        @(posedge clk);
        mstep(s, w, a, d);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd2, '0);
    endtask

    task automatic peek(input int k, input logic [1:0] a, input logic [31:0] exp, input string tag);
        sel = 1'b0; addr = a;
        #1;
        chk(tag, k == 0 ? rdata1 : rdata4, exp);
    endtask

    task automatic peek_irq(input logic exp, input string tag);
        #1;
        chk(tag, {31'd0, irq1}, {31'd0, exp});
    endtask

    initial begin
        idle();
        rst = 1'b0;
        chk_en = 1'b1;
        wr(1, 5); wr(0, 7);
        repeat (3) idle();
        rst = 1'b1; idle(); rst = 1'b0;
        for (int a = 0; a < 4; a++) peek(0, 2'(a), 0, "reset_rd");
        peek_irq(1'b0, "reset_irq");

        wr(0, 0); wr(3, 1); wr(1, 3); wr(0, 7);
        peek(0, 2, 3, "per_v3");
        idle(); peek(0, 2, 2, "per_v2");
        idle(); peek(0, 2, 1, "per_v1");
        idle(); peek(0, 2, 0, "per_v0"); peek(0, 3, 0, "per_tc0");
        idle(); peek(0, 2, 3, "per_reload"); peek(0, 3, 1, "per_tc1"); peek_irq(1'b1, "per_irq");
        wr(3, 1); peek(0, 3, 0, "per_w1c");
        idle(); idle(); peek(0, 3, 0, "per_tc_hold");
        idle(); peek(0, 3, 1, "per_tc_again");
        repeat (3) idle();
        wr(3, 1); peek(0, 3, 1, "w1c_vs_set"); peek(0, 2, 3, "per_reload2");
        wr(2, 32'h100); peek(0, 2, 32'h100, "value_wr_tick");

        wr(0, 0); wr(3, 1); wr(1, 2); wr(0, 1);
        peek(0, 2, 2, "os_v2");
        repeat (3) idle();
        peek(0, 3, 1, "os_tc"); peek(0, 0, 0, "os_ctrl");
        repeat (10) idle();
        peek(0, 2, 0, "os_v_hold"); peek_irq(1'b0, "os_irq");

        wr(0, 0); wr(3, 1); wr(1, 1); wr(0, 3);
        peek(1, 2, 1, "ps4_v1");
        repeat (3) idle(); peek(1, 2, 1, "ps4_v1_hold");
        idle(); peek(1, 2, 0, "ps4_v0");
        repeat (3) idle(); peek(1, 3, 0, "ps4_tc0");
        idle(); peek(1, 3, 1, "ps4_tc1"); peek(1, 2, 1, "ps4_reload");

        wr(0, 0); wr(1, 0); wr(3, 1); wr(0, 3);
        peek(0, 3, 0, "l0_tc0");
        idle(); peek(0, 3, 1, "l0_tc1");
        for (int i = 0; i < 3; i++) begin
            wr(3, 1); peek(0, 3, 1, "l0_every");
        end

        wr(0, 0); wr(1, 32'hFFFF_FFFF); wr(0, 3);
        peek(0, 2, 32'hFFFF_FFFF, "max_load");
        wr(2, 1); peek(0, 2, 1, "max_v1");
        idle(); peek(0, 2, 0, "max_v0");
        idle(); peek(0, 2, 32'hFFFF_FFFF, "max_reload");

        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a = 2'($urandom_range(0, 3));
            logic [31:0] d;
            bit          w = $urandom_range(0, 3) == 0;
            case (a)
                2'd0: d = 32'($urandom_range(0, 7)) | ($urandom_range(0, 2) != 0 ? 32'd1 : 32'd0);
                2'd3: d = 32'($urandom_range(0, 1));
                default: d = $urandom_range(0, 9) == 0 ? $urandom : 32'($urandom_range(0, 6));
            endcase
            rst = $urandom_range(0, 199) == 0;
            step(w, w, a, d);
        end
        rst = 1'b0;
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Memory-mapped 32-bit down-counting timer with reload, one-shot/periodic modes, a fixed prescaler and a sticky terminal-count interrupt. It sits on the core's data-memory peripheral bus alongside the other MMIO slaves. It supplies the timer interrupt request to the core's interrupt logic. It is the decrementing, bus-programmed counterpart of the core's up-counting load/enable program counter.

## Interface
- PRESCALE, default 1: core clock cycles per timer tick; legal range 1..65536.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  1  slave select; an access occurs only when sel=1.
- we  in  1  1 = write, 0 = read; qualified by sel.
- addr  in  2  word index: 0 CTRL, 1 LOAD, 2 VALUE, 3 STATUS.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr and the current registers, independent of sel.
- irq  out  1  interrupt request, level: tc & irq_en.

## Operation
- Registers:
  - CTRL: bit0 en, bit1 periodic, bit2 irq_en. Bits 31:3 read 0 and ignore writes.
  - LOAD: 32-bit reload value.
  - VALUE: 32-bit current count.
  - STATUS: bit0 tc (sticky). Writing 1 to bit0 clears tc; writing 0 has no effect. Bits 31:1 read 0.
- Reset values: CTRL=0, LOAD=0, VALUE=0, tc=0, prescaler=0, state IDLE. Therefore rdata=0 for every address and irq=0.
- States:
  - IDLE: entered when en=0.
  - RUN: entered when en=1.
- Transitions:
  - IDLE->RUN on a CTRL write with wdata[0]=1. The same edge loads VALUE<=LOAD (using LOAD's value before that edge) and clears the prescaler to 0.
  - RUN->IDLE on a CTRL write with wdata[0]=0, or on a one-shot expiry.
  - A CTRL write with en=1 while already in RUN only updates periodic and irq_en. It does not reload VALUE and does not reset the prescaler.
- Prescaler:
  - The counter runs only in RUN.
  - tick=1 when the prescaler equals PRESCALE-1. The prescaler then wraps to 0; otherwise it increments.
  - With PRESCALE=1, tick=1 on every RUN cycle.
- On each tick in RUN:
  - If VALUE != 0: VALUE <= VALUE-1.
  - If VALUE == 0: tc <= 1. If periodic=1, VALUE <= LOAD and the timer stays in RUN. If periodic=0, the en bit clears, the state goes to IDLE and VALUE stays 0.
  - Period is therefore LOAD+1 ticks. LOAD=0 in periodic mode sets tc on every tick.
- Arithmetic: unsigned 32-bit. VALUE never wraps below 0.
- Simultaneous events, in priority order:
  - rst overrides everything.
  - A bus write to VALUE on a tick edge wins: VALUE takes wdata and there is no decrement or reload.
  - A bus write to LOAD on an expiry tick: the reload uses the old LOAD; the new LOAD takes effect from the next reload.
  - A tc set and a STATUS W1C on the same edge: the set wins and tc stays 1.
  - A CTRL write with en=0 on a one-shot expiry edge: the result is IDLE, and tc is still set.
- Writes to VALUE in IDLE are accepted. The counter does not run while IDLE.
- Reads have no side effects.

## Timing
- Write at edge N: the register holds the new value after edge N, and rdata reflects it in cycle N+1.
- Enable latency, with PRESCALE=1 and CTRL(en=1) written at edge N: VALUE=LOAD after N; the first decrement is at edge N+1. VALUE reaches 0 after edge N+LOAD, and tc=1 after edge N+LOAD+1.
- irq follows tc and irq_en combinationally: it is high in the same cycle tc or irq_en becomes 1.
- A synchronous reset asserted mid-count returns every register to its reset value at the next edge. No tick is lost or generated on that edge.

## Test plan
- **Reset:** run with CTRL=7, LOAD=5, then assert rst for 1 cycle -> all four reads return 0 and irq=0 on the following cycle.
- **Periodic:** PRESCALE=1, LOAD=3, CTRL=0b111 written at edge N -> VALUE reads 3,2,1,0 after edges N..N+3. After N+4, VALUE=3 and tc=irq=1. STATUS write 1 -> tc=0, and tc sets again 4 edges after the previous set.
- **One-shot:** LOAD=2, CTRL=0b001 -> after 3 ticks tc=1, CTRL reads 0, VALUE stays 0 for 10 more cycles, irq=0 because irq_en=0.
- **Prescaler:** PRESCALE=4, LOAD=1, periodic -> VALUE changes every 4 cycles and tc sets 8 cycles after the enable edge.
- **Collisions:**
  - Write VALUE=0x100 on a tick edge -> VALUE reads 0x100, not 0xFF or reloaded.
  - Write STATUS=1 on the tc-set edge -> tc reads 1.
- **Edge values:**
  - LOAD=0, periodic -> tc on every cycle.
  - LOAD=0xFFFFFFFF, VALUE written to 1 -> decrements to 0, then reloads to 0xFFFFFFFF without wrapping.
